// File: rtl/pipe_idstage_pkg.sv
// pipe_idstage_pkg: opcodes, funct codes, ALU/pcsrc encodings and ID-stage types
package pipe_idstage_pkg;
  localparam logic [5:0] OP_R = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0c, OP_ORI = 6'h0d, OP_XORI = 6'h0e;
  localparam logic [5:0] OP_LUI = 6'h0f, OP_LW = 6'h23, OP_SW = 6'h2b;
  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_JR = 6'h08;
  localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26;
  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0100, ALU_AND = 4'b0001, ALU_OR = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010, ALU_LUI = 4'b0110, ALU_SLL = 4'b0011, ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;
  localparam logic [1:0] PC_PC4 = 2'd0, PC_BPC = 2'd1, PC_JR = 2'd2, PC_JPC = 2'd3;
  typedef enum logic {RUN, LDSTALL} state_t;
  typedef struct packed {
    logic       wreg;
    logic       m2reg;
    logic       wmem;
    logic       aluimm;
    logic       shift;
    logic       jal;
    logic [3:0] aluc;
  } ctrl_t;
endpackage

// File: rtl/pipe_idstage_if.sv
// pipe_idstage_if: IF/EX/MEM-facing signals of the decode stage
interface pipe_idstage_if;
  logic [31:0] finst, fpc4, qa, qb, ealu, malu, mmo;
  logic [4:0]  ern, mrn;
  logic        ewreg, em2reg, mwreg, mm2reg;
  logic [4:0]  rs, rt, drn;
  logic        wpcir, dwreg, dm2reg, dwmem, daluimm, dshift, djal;
  logic [1:0]  pcsrc;
  logic [3:0]  daluc;
  logic [31:0] bpc, jpc, da, db, dimm, dpc4;
  logic [15:0] stall_cnt;
  modport slave (
    input  finst, fpc4, qa, qb, ealu, malu, mmo, ern, mrn, ewreg, em2reg, mwreg, mm2reg,
    output rs, rt, drn, wpcir, dwreg, dm2reg, dwmem, daluimm, dshift, djal, pcsrc, daluc,
    output bpc, jpc, da, db, dimm, dpc4, stall_cnt
  );
  modport master (
    output finst, fpc4, qa, qb, ealu, malu, mmo, ern, mrn, ewreg, em2reg, mwreg, mm2reg,
    input  rs, rt, drn, wpcir, dwreg, dm2reg, dwmem, daluimm, dshift, djal, pcsrc, daluc,
    input  bpc, jpc, da, db, dimm, dpc4, stall_cnt
  );
endinterface

// File: rtl/pipe_idctrl.sv
// pipe_idctrl: combinational instruction decoder for the ID stage
module pipe_idctrl
  import pipe_idstage_pkg::*;
(
  input  logic [31:0] inst,
  input  logic        equ,
  output ctrl_t       ctrl,
  output logic [1:0]  pcsrc,
  output logic [31:0] imm,
  output logic [4:0]  rn,
  output logic        use_rs,
  output logic        use_rt
);
  logic [5:0] op, fn;
  logic r, i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr;
  logic i_addi, i_andi, i_ori, i_xori, i_lui, i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  logic r_alu, shift, i_alu, sext;
  assign op = inst[31:26];
  assign fn = inst[5:0];
  assign r = op == OP_R;
  assign i_add = r & (fn == F_ADD);
  assign i_sub = r & (fn == F_SUB);
  assign i_and = r & (fn == F_AND);
  assign i_or = r & (fn == F_OR);
  assign i_xor = r & (fn == F_XOR);
  assign i_sll = r & (fn == F_SLL);
  assign i_srl = r & (fn == F_SRL);
  assign i_sra = r & (fn == F_SRA);
  assign i_jr = r & (fn == F_JR);
  assign i_addi = op == OP_ADDI;
  assign i_andi = op == OP_ANDI;
  assign i_ori = op == OP_ORI;
  assign i_xori = op == OP_XORI;
  assign i_lui = op == OP_LUI;
  assign i_lw = op == OP_LW;
  assign i_sw = op == OP_SW;
  assign i_beq = op == OP_BEQ;
  assign i_bne = op == OP_BNE;
  assign i_j = op == OP_J;
  assign i_jal = op == OP_JAL;
  assign r_alu = i_add | i_sub | i_and | i_or | i_xor;
  assign shift = i_sll | i_srl | i_sra;
  assign i_alu = i_addi | i_andi | i_ori | i_xori | i_lui;
  assign sext = i_addi | i_lw | i_sw | i_beq | i_bne;
  assign rn = i_jal ? 5'd31 : r ? inst[15:11] : inst[20:16];
  // writes to $0 are dropped here so an all-zero word (sll $0) is a true NOP
  assign ctrl.wreg = (r_alu | shift | i_alu | i_lw | i_jal) & (rn != 5'd0);
  assign ctrl.m2reg = i_lw;
  assign ctrl.wmem = i_sw;
  assign ctrl.aluimm = i_alu | i_lw | i_sw;
  assign ctrl.shift = shift;
  assign ctrl.jal = i_jal;
  assign ctrl.aluc = (i_sub | i_beq | i_bne) ? ALU_SUB : (i_and | i_andi) ? ALU_AND :
                     (i_or | i_ori) ? ALU_OR : (i_xor | i_xori) ? ALU_XOR : i_lui ? ALU_LUI :
                     i_sll ? ALU_SLL : i_srl ? ALU_SRL : i_sra ? ALU_SRA : ALU_ADD;
  assign imm = {{16{sext & inst[15]}}, inst[15:0]};
  assign use_rs = r_alu | i_jr | i_addi | i_andi | i_ori | i_xori | i_lw | i_sw | i_beq | i_bne;
  assign use_rt = r_alu | shift | i_sw | i_beq | i_bne;
  assign pcsrc = i_jr ? PC_JR : (i_j | i_jal) ? PC_JPC :
                 ((i_beq & equ) | (i_bne & ~equ)) ? PC_BPC : PC_PC4;
endmodule

// File: rtl/pipe_idstage.sv
// pipe_idstage: IF/ID register, forwarding, load-use stall FSM and branch resolution
module pipe_idstage
  import pipe_idstage_pkg::*;
(
  input logic            clk,
  input logic            clrn,
  pipe_idstage_if.slave  b
);
  logic [31:0] dinst, dpc4;
  logic [15:0] cnt;
  logic [4:0]  rs, rt;
  logic        equ, use_rs, use_rt, hazard, wpcir, flush;
  state_t      state;
  ctrl_t       c;
  assign rs = dinst[25:21];
  assign rt = dinst[20:16];
  assign b.rs = rs;
  assign b.rt = rt;
  assign b.da = (b.ewreg & ~b.em2reg & (b.ern != 5'd0) & (b.ern == rs)) ? b.ealu :
                (b.mwreg & (b.mrn != 5'd0) & (b.mrn == rs)) ? (b.mm2reg ? b.mmo : b.malu) : b.qa;
  assign b.db = (b.ewreg & ~b.em2reg & (b.ern != 5'd0) & (b.ern == rt)) ? b.ealu :
                (b.mwreg & (b.mrn != 5'd0) & (b.mrn == rt)) ? (b.mm2reg ? b.mmo : b.malu) : b.qb;
  assign equ = b.da == b.db;
  pipe_idctrl u_ctrl (
    .inst(dinst), .equ(equ), .ctrl(c), .pcsrc(b.pcsrc), .imm(b.dimm), .rn(b.drn),
    .use_rs(use_rs), .use_rt(use_rt)
  );
  assign hazard = b.ewreg & b.em2reg & (b.ern != 5'd0) &
                  ((use_rs & (b.ern == rs)) | (use_rt & (b.ern == rt)));
  assign wpcir = !(state == RUN && hazard);
  assign flush = wpcir & (b.pcsrc != PC_PC4);
  assign b.wpcir = wpcir;
  assign b.dwreg = c.wreg & wpcir;
  assign b.dm2reg = c.m2reg & wpcir;
  assign b.dwmem = c.wmem & wpcir;
  assign b.djal = c.jal & wpcir;
  assign b.daluimm = c.aluimm;
  assign b.dshift = c.shift;
  assign b.daluc = c.aluc;
  assign b.dpc4 = dpc4;
  assign b.stall_cnt = cnt;
  assign b.bpc = dpc4 + {{14{dinst[15]}}, dinst[15:0], 2'b00};
  assign b.jpc = {dpc4[31:28], dinst[25:0], 2'b00};
  always_ff @(posedge clk or posedge clrn)
    if (clrn) begin
      dinst <= '0;
      dpc4 <= '0;
      cnt <= '0;
      state <= RUN;
    end else begin
      state <= (state == RUN && hazard) ? LDSTALL : RUN;
      if (flush) begin
        dinst <= '0;
        dpc4 <= '0;
      end else if (wpcir) begin
        dinst <= b.finst;
        dpc4 <= b.fpc4;
      end
      if (!wpcir && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
endmodule

// File: tb/tb_pipe_idstage.sv
// tb_pipe_idstage: directed checks of decode, forwarding, load-use stall, branches and reset
module tb_pipe_idstage;
  logic clk = 1'b0;
  logic clrn;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  pipe_idstage_if bus();
  pipe_idstage dut (.clk(clk), .clrn(clrn), .b(bus));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic clr_fwd();
    bus.ern = 0; bus.ewreg = 0; bus.em2reg = 0; bus.ealu = 0;
    bus.mrn = 0; bus.mwreg = 0; bus.mm2reg = 0; bus.malu = 0; bus.mmo = 0;
  endtask
  logic [31:0] t_inst [10] = '{32'h8C24FFFC, 32'hAC240008, 32'h34268000, 32'h000238C0, 32'h000238C3,
                               32'h00224022, 32'h2029FFFE, 32'h3C0A1234, 32'hFC000000, 32'h382BFFFF};
  logic [3:0]  t_aluc [10] = '{4'h0, 4'h0, 4'h5, 4'h3, 4'hF, 4'h4, 4'h0, 4'h6, 4'h0, 4'h2};
  logic [4:0]  t_drn  [10] = '{5'd4, 5'd4, 5'd6, 5'd7, 5'd7, 5'd8, 5'd9, 5'd10, 5'd0, 5'd11};
  logic [31:0] t_imm  [10] = '{32'hFFFFFFFC, 32'h8, 32'h8000, 32'h38C0, 32'h38C3,
                               32'h4022, 32'hFFFFFFFE, 32'h1234, 32'h0, 32'hFFFF};
  // {dwreg, dm2reg, dwmem, daluimm, dshift}
  logic [4:0]  t_flg  [10] = '{5'b11010, 5'b00110, 5'b10010, 5'b10001, 5'b10001,
                               5'b10000, 5'b10010, 5'b10010, 5'b00000, 5'b10010};
  initial begin
    clr_fwd();
    bus.finst = 0; bus.fpc4 = 0; bus.qa = 0; bus.qb = 0;
    clrn = 1'b1;
    #3;
    chk("rst_wpcir", bus.wpcir, 1);
    chk("rst_pcsrc", bus.pcsrc, 0);
    chk("rst_dwreg", bus.dwreg, 0);
    chk("rst_dwmem", bus.dwmem, 0);
    chk("rst_cnt", bus.stall_cnt, 0);
    chk("rst_dpc4", bus.dpc4, 0);
    @(negedge clk);
    clrn = 1'b0;
    // add $3,$1,$2
    bus.finst = 32'h00221820; bus.fpc4 = 32'h104; bus.qa = 5; bus.qb = 7;
    step();
    chk("add_rs", bus.rs, 1);
    chk("add_rt", bus.rt, 2);
    chk("add_da", bus.da, 5);
    chk("add_db", bus.db, 7);
    chk("add_aluc", bus.daluc, 0);
    chk("add_drn", bus.drn, 3);
    chk("add_dwreg", bus.dwreg, 1);
    chk("add_dpc4", bus.dpc4, 32'h104);
    bus.ern = 1; bus.ewreg = 1; bus.ealu = 32'h10; bus.mrn = 1; bus.mwreg = 1; bus.malu = 32'h20;
    #1;
    chk("fwd_ex_prio", bus.da, 32'h10);
    chk("fwd_ex_db", bus.db, 7);
    bus.ewreg = 0;
    #1;
    chk("fwd_mem_alu", bus.da, 32'h20);
    bus.mm2reg = 1; bus.mmo = 32'h30;
    #1;
    chk("fwd_mem_mo", bus.da, 32'h30);
    bus.mrn = 2;
    #1;
    chk("fwd_mem_rt_da", bus.da, 5);
    chk("fwd_mem_rt_db", bus.db, 32'h30);
    clr_fwd();
    bus.ern = 1; bus.ewreg = 1; bus.em2reg = 1;
    bus.mrn = 0; bus.mwreg = 1; bus.malu = 32'h99;
    #1;
    chk("fwd_r0_ignored", bus.db, 7);
    clr_fwd();
    // load-use: lw $4 in EX, add $5,$4,$4 in ID
    bus.finst = 32'h00842820; bus.fpc4 = 32'h108;
    step();
    bus.ern = 4; bus.ewreg = 1; bus.em2reg = 1;
    #1;
    chk("lu_wpcir", bus.wpcir, 0);
    chk("lu_dwreg", bus.dwreg, 0);
    chk("lu_cnt0", bus.stall_cnt, 0);
    bus.finst = 32'h00221820; bus.fpc4 = 32'h10C;
    step();
    clr_fwd();
    bus.mrn = 4; bus.mwreg = 1; bus.mm2reg = 1; bus.mmo = 32'hABCD;
    #1;
    chk("ls_cnt", bus.stall_cnt, 1);
    chk("ls_wpcir", bus.wpcir, 1);
    chk("ls_dwreg", bus.dwreg, 1);
    chk("ls_hold_drn", bus.drn, 5);
    chk("ls_hold_dpc4", bus.dpc4, 32'h108);
    chk("ls_da", bus.da, 32'hABCD);
    chk("ls_db", bus.db, 32'hABCD);
    step();
    clr_fwd();
    bus.ern = 1; bus.ewreg = 1; bus.em2reg = 1;
    #1;
    chk("run_drn", bus.drn, 3);
    chk("run_again_stall", bus.wpcir, 0);
    chk("run_cnt", bus.stall_cnt, 1);
    clr_fwd();
    // beq $1,$2,-1 at dpc4 0x100, rt forwarded from EX
    bus.finst = 32'h1022FFFF; bus.fpc4 = 32'h100;
    step();
    bus.qa = 9; bus.qb = 3; bus.ern = 2; bus.ewreg = 1; bus.ealu = 9;
    #1;
    chk("beq_db_fwd", bus.db, 9);
    chk("beq_pcsrc", bus.pcsrc, 1);
    chk("beq_bpc", bus.bpc, 32'hFC);
    bus.ealu = 8;
    #1;
    chk("beq_not_taken", bus.pcsrc, 0);
    bus.ealu = 9;
    bus.finst = 32'h00221820; bus.fpc4 = 32'h104;
    step();
    chk("beq_flush_pc4", bus.dpc4, 0);
    chk("beq_flush_pcsrc", bus.pcsrc, 0);
    chk("beq_flush_dwreg", bus.dwreg, 0);
    clr_fwd();
    // jal 0x40 at dpc4 0x1000_0004
    bus.finst = 32'h0C000040; bus.fpc4 = 32'h10000004;
    step();
    chk("jal_pcsrc", bus.pcsrc, 3);
    chk("jal_jpc", bus.jpc, 32'h10000100);
    chk("jal_djal", bus.djal, 1);
    chk("jal_drn", bus.drn, 31);
    chk("jal_dwreg", bus.dwreg, 1);
    bus.finst = 32'h00200008; bus.fpc4 = 32'h200;
    step();
    chk("jal_flush", bus.dpc4, 0);
    step();
    bus.qa = 32'h1234;
    #1;
    chk("jr_pcsrc", bus.pcsrc, 2);
    chk("jr_da", bus.da, 32'h1234);
    chk("jr_dwreg", bus.dwreg, 0);
    bus.finst = t_inst[0];
    step();
    chk("jr_flush", bus.dpc4, 0);
    for (int i = 0; i < 10; i++) begin
      bus.finst = t_inst[i];
      step();
      chk($sformatf("dec%0d_aluc", i), bus.daluc, t_aluc[i]);
      chk($sformatf("dec%0d_drn", i), bus.drn, t_drn[i]);
      chk($sformatf("dec%0d_imm", i), bus.dimm, t_imm[i]);
      chk($sformatf("dec%0d_flags", i), {bus.dwreg, bus.dm2reg, bus.dwmem, bus.daluimm, bus.dshift}, t_flg[i]);
      chk($sformatf("dec%0d_pcsrc", i), bus.pcsrc, 0);
    end
    // reset while in LDSTALL
    bus.finst = 32'h00842820; bus.fpc4 = 32'h300;
    step();
    bus.ern = 4; bus.ewreg = 1; bus.em2reg = 1;
    #1;
    chk("rs_bubble", bus.wpcir, 0);
    step();
    chk("rs_cnt2", bus.stall_cnt, 2);
    #2;
    clrn = 1'b1;
    #1;
    chk("rs_async_cnt", bus.stall_cnt, 0);
    chk("rs_async_wpcir", bus.wpcir, 1);
    chk("rs_async_dpc4", bus.dpc4, 0);
    @(negedge clk);
    clrn = 1'b0;
    step();
    chk("rs_run_state", bus.wpcir, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_idstage.md
PIPE_IDSTAGE -- requirements
Module: pipe_idstage

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 clrn  in  1  reset; asynchronous, active-high.
REQ-003 finst, fpc4  in  32 each  IF-stage instruction and PC+4.
REQ-004 qa, qb  in  32 each  register-file read data for rs, rt.
REQ-005 ern, mrn  in  5 each; ewreg, em2reg, mwreg, mm2reg  in  1 each  EX/MEM destination and control.
REQ-006 ealu, malu, mmo  in  32 each  forwarding sources: EX ALU result, MEM ALU result, MEM load data.
REQ-007 rs, rt  out  5 each  register-file read addresses, equal to dinst[25:21] and dinst[20:16].
REQ-008 wpcir  out  1  PC and IF/ID write enable.
REQ-009 pcsrc  out  2  next-PC select: 0 pc4, 1 bpc, 2 da (jr), 3 jpc.
REQ-010 bpc, jpc  out  32 each  branch target and jump target.
REQ-011 dwreg, dm2reg, dwmem, daluimm, dshift, djal  out  1 each  ID/EX control.
REQ-012 daluc  out  4  ALU op.
REQ-013 da, db, dimm, dpc4  out  32 each  ID/EX data.
REQ-014 drn  out  5  destination register.
REQ-015 stall_cnt  out  16  saturating count of load-use stall cycles.

Function
REQ-016 IF/ID register (dinst, dpc4) SHALL load finst/fpc4 on clk when wpcir=1, hold when wpcir=0, and load 0 (NOP) when a flush is pending.
REQ-017 Decoder SHALL support add, sub, and, or, xor, sll, srl, sra, jr, addi, andi, ori, xori, lw, sw, beq, bne, lui, j, jal; any other opcode SHALL decode as NOP (dwreg=dwmem=0).
REQ-018 daluc encoding: add 0000, sub 0100, and 0001, or 0101, xor 0010, lui 0110, sll 0011, srl 0111, sra 1111; lw/sw/addi/beq/bne use add/sub as appropriate.
REQ-019 dimm: sign-extend imm16 for addi, lw, sw, beq, bne; zero-extend for andi, ori, xori; dshift=1 for sll/srl/sra; djal=1 only for jal.
REQ-020 drn: rd for R-type, rt for I-type, 31 for jal (EX additionally ORs ejal).
REQ-021 Forwarding for da (same for db with rt): ern when ewreg=1, em2reg=0, ern!=0, ern=rs -> ealu; else mrn when mwreg=1, mrn!=0, mrn=rs -> (mm2reg ? mmo : malu); else qa; EX match has priority over MEM.
REQ-022 Load-use hazard: ewreg=1, em2reg=1, ern!=0, ern equals a source register actually read by dinst.
REQ-023 Two-state FSM RUN/LDSTALL: RUN->LDSTALL on load-use hazard; LDSTALL->RUN unconditionally next cycle.
REQ-024 In RUN with hazard: wpcir=0 and dwreg=dm2reg=dwmem=djal=0 (bubble) while the instruction stays in IF/ID; in LDSTALL: wpcir=1, normal decode, with forwarding from mmo.
REQ-025 Branch compare SHALL use forwarded da/db; beq taken when equal, bne when unequal; bpc = dpc4 + (sign-extended imm16 << 2) mod 2^32; jpc = {dpc4[31:28], addr26, 2'b00}.
REQ-026 Taken branch, j, jal or jr SHALL set pcsrc and flush IF/ID on the next clk (one bubble, no delay slot); a flush is suppressed while the load-use bubble is being issued (wpcir=0).
REQ-027 stall_cnt SHALL increment each cycle wpcir=0 and saturate at 16'hFFFF.

Reset
REQ-028 clrn=1 SHALL asynchronously clear dinst, dpc4, stall_cnt to 0 and FSM to RUN; all decoded outputs then reflect a NOP (dwreg=dwmem=0, pcsrc=0, wpcir=1).

Structure
REQ-029 Shared package SHALL hold opcode/funct constants, daluc codes, pcsrc codes and the FSM state enum.
REQ-030 Decoder SHALL be one sub-module, pipe_idctrl (combinational); forwarding, FSM, IF/ID register and counter stay in the top.

Verification
REQ-031 add $3,$1,$2 with qa=5, qb=7 -> da=5, db=7, daluc=0000, drn=3, dwreg=1.
REQ-032 ern=1, ewreg=1, em2reg=0, ealu=0x10, dinst uses rs=1 -> da=0x10 even when malu differs and mrn=1.
REQ-033 lw $4 in EX, next dinst add $5,$4,$4 -> one cycle wpcir=0, dwreg=0, stall_cnt=1; next cycle da=db=mmo, FSM returns to RUN.
REQ-034 beq with equal forwarded operands, imm16=0xFFFF, dpc4=0x100 -> pcsrc=1, bpc=0xFC, dinst=0 next cycle.
REQ-035 jal addr26=0x40 at dpc4=0x1000_0004 -> pcsrc=3, jpc=0x1000_0100, djal=1, drn=31.
REQ-036 Assert clrn mid-stall -> FSM RUN, stall_cnt=0, wpcir=1 immediately without a clock edge.
